issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
- Sits between the instruction decoder and the execute stage.
- Holds a 32-entry register scoreboard and stalls decoded instructions on RAW/WAW hazards.
- Shares a single multi-cycle multiply/divide unit (MDU) and sequences it with a small FSM.
- The single-cycle ALU path writes back through an external writeback port; this block only tracks pending destinations.

Parameters:
- NREGS, 32, number of architectural integer registers.
- RIDX_W, 5, register index width (log2 NREGS).
- STAT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dec_valid  in  1  decoded instruction present.
- dec_ready  out  1  instruction accepted this cycle.
- dec_rd  in  RIDX_W  destination register.
- dec_rs1  in  RIDX_W  source register 1.
- dec_rs2  in  RIDX_W  source register 2.
- dec_use_rs1  in  1  instruction reads rs1.
- dec_use_rs2  in  1  instruction reads rs2.
- dec_wr_rd  in  1  instruction writes rd.
- dec_is_md  in  1  instruction is mul/mulh/mulhsu/mulhu/div/divu/rem/remu or a W variant.
- alu_issue  out  1  one-cycle pulse: issue to the ALU.
- md_start  out  1  one-cycle pulse: start the MDU.
- md_rd  out  RIDX_W  destination held for the MDU operation.
- md_done  in  1  MDU result valid (single-cycle pulse).
- md_kill  out  1  abort the MDU operation.
- md_wb_valid  out  1  MDU writeback strobe.
- alu_wb_valid  in  1  ALU writeback occurring.
- alu_wb_rd  in  RIDX_W  register being written back by the ALU.
- flush  in  1  pipeline flush (branch/jump redirect).
- md_busy  out  1  MDU FSM is not IDLE.

Behaviour:
- Reset: all pending bits 0, FSM IDLE, md_rd 0; every output 0 except dec_ready, which follows the issue rule.
- hazard = (use_rs1 & pend[rs1]) | (use_rs2 & pend[rs2]) | (wr_rd & pend[rd]).
- pend[0] is hard-wired 0, so register index 0 never stalls.
- dec_ready is combinational: !flush & !hazard & (!dec_is_md | state==IDLE). Instructions without dec_is_md issue even while the MDU is busy.
- Issue occurs when dec_valid & dec_ready.
  - Non-MDU issue: alu_issue=1 in the same cycle.
  - MDU issue: md_start=1 in the same cycle; md_rd is latched; FSM moves IDLE->BUSY.
- Scoreboard set: on issue with dec_wr_rd and rd!=0, pend[rd] is 1 from the next cycle.
- Scoreboard clear:
  - alu_wb_valid clears pend[alu_wb_rd].
  - The FSM WB state clears pend[md_rd].
  - If a set and a clear target the same index in the same cycle, the set wins.
- FSM:
  - IDLE: waits for an MDU issue, then goes to BUSY.
  - BUSY: on md_done goes to WB. md_done while in IDLE or WB is ignored.
  - WB: md_wb_valid=1 for exactly one cycle, then IDLE.
- MDU back-to-back: the earliest a new MDU instruction can issue is the cycle after WB. Latency from md_done to the next md_start is 2 cycles minimum.
- flush (highest priority):
  - No issue in that cycle.
  - All pending bits cleared next cycle.
  - If the FSM is BUSY or WB: md_kill=1 for one cycle, FSM goes to IDLE, and no md_wb_valid is generated.
- reset mid-operation: returns to the reset state regardless of FSM state; md_kill is not asserted.
- alu_wb_valid for a register that is not pending has no effect.

Optional Feature:
- Macro: ISSUE_SCHED_STATS_EN.
- When defined, adds three counters, each STAT_W bits, saturating, zeroed by reset:
  - stat_issued: counts issues.
  - stat_hazard_stall: counts cycles with dec_valid & hazard & !flush.
  - stat_md_stall: counts cycles with dec_valid & dec_is_md & !hazard & state!=IDLE & !flush.
- Each counter has an output port of the same name.
- When not defined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Package issue_pkg holds:
  - md_state_e enum (IDLE, BUSY, WB).
  - NREGS/RIDX_W defaults.
  - A typedef for the decoded-instruction bundle (rd, rs1, rs2, use flags, wr_rd, is_md).
- Sub-module scoreboard: pending-bit array with set/clear ports, the set-wins rule, flush clear, and combinational lookup of rs1/rs2/rd.

Test Plan:
- Independent ALU ops (add x5,x1,x2 then add x6,x3,x4) -> both issue on consecutive cycles; alu_issue high 2 cycles.
- RAW hazard: add x5 issued; next instruction reads x5 -> dec_ready=0 until alu_wb_valid with rd=5; issue occurs the cycle after the writeback.
- MDU sequence: mul x7 issued; md_done returned 4 cycles later -> md_busy high 5 cycles; md_wb_valid one cycle; second mul blocked meanwhile while add x8 issues freely.
- Same-cycle set/clear: alu_wb_valid rd=9 in the same cycle a new instruction with rd=9 issues -> pend[9] stays 1 next cycle.
- Flush during BUSY -> md_kill pulse; FSM IDLE; all pending bits clear; a later md_done causes no md_wb_valid.
- Writes to x0 and reads of x0 -> never stall; reset asserted mid-BUSY -> md_busy=0 and all pending bits clear the next cycle.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// Shared types and default sizes for the issue scheduler (package issue_pkg).
// ISSUE_SCHED_STATS_EN in the top adds saturating statistics counters.
package issue_pkg;

  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned RIDX_W_DEF = 5;
  localparam int unsigned STAT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [RIDX_W_DEF-1:0] rd;
    logic [RIDX_W_DEF-1:0] rs1;
    logic [RIDX_W_DEF-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
    logic                  wr_rd;
    logic                  is_md;
  } dec_instr_t;

endpackage

// File: rtl/issue_scheduler_scoreboard.sv
// Register pending-bit array: set beats clear on the same index, flush clears all,
// register 0 is never pending.
module scoreboard #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned RIDX_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              set_en,
  input  logic [RIDX_W-1:0] set_idx,
  input  logic              clr_a_en,
  input  logic [RIDX_W-1:0] clr_a_idx,
  input  logic              clr_b_en,
  input  logic [RIDX_W-1:0] clr_b_idx,
  input  logic [RIDX_W-1:0] rs1_idx,
  input  logic [RIDX_W-1:0] rs2_idx,
  input  logic [RIDX_W-1:0] rd_idx,
  output logic              rs1_pend,
  output logic              rs2_pend,
  output logic              rd_pend
);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] pend_next;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en)   set_mask[set_idx]   = 1'b1;
    if (clr_a_en) clr_mask[clr_a_idx] = 1'b1;
    if (clr_b_en) clr_mask[clr_b_idx] = 1'b1;
    pend_next    = (pend & ~clr_mask) | set_mask;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

  assign rs1_pend = pend[rs1_idx];
  assign rs2_pend = pend[rs2_idx];
  assign rd_pend  = pend[rd_idx];

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler: scoreboard hazard stalls plus sequencing of the shared MDU.
// Optional statistics counters are enabled by ISSUE_SCHED_STATS_EN.
module issue_scheduler
  import issue_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned RIDX_W = RIDX_W_DEF
`ifdef ISSUE_SCHED_STATS_EN
  ,
  parameter int unsigned STAT_W = STAT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [RIDX_W-1:0] dec_rd,
  input  logic [RIDX_W-1:0] dec_rs1,
  input  logic [RIDX_W-1:0] dec_rs2,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic              dec_wr_rd,
  input  logic              dec_is_md,
  output logic              alu_issue,
  output logic              md_start,
  output logic [RIDX_W-1:0] md_rd,
  input  logic              md_done,
  output logic              md_kill,
  output logic              md_wb_valid,
  input  logic              alu_wb_valid,
  input  logic [RIDX_W-1:0] alu_wb_rd,
  input  logic              flush,
`ifdef ISSUE_SCHED_STATS_EN
  output logic [STAT_W-1:0] stat_issued,
  output logic [STAT_W-1:0] stat_hazard_stall,
  output logic [STAT_W-1:0] stat_md_stall,
`endif
  output logic              md_busy
);

  dec_instr_t instr;
  md_state_e  state;
  logic       rs1_pend, rs2_pend, rd_pend;
  logic       hazard;
  logic       issue;

  assign instr = '{rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, use_rs1: dec_use_rs1,
                   use_rs2: dec_use_rs2, wr_rd: dec_wr_rd, is_md: dec_is_md};

  scoreboard #(
    .NREGS  (NREGS),
    .RIDX_W (RIDX_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .set_en    (issue & instr.wr_rd & (instr.rd != '0)),
    .set_idx   (instr.rd),
    .clr_a_en  (alu_wb_valid),
    .clr_a_idx (alu_wb_rd),
    .clr_b_en  (state == WB),
    .clr_b_idx (md_rd),
    .rs1_idx   (instr.rs1),
    .rs2_idx   (instr.rs2),
    .rd_idx    (instr.rd),
    .rs1_pend  (rs1_pend),
    .rs2_pend  (rs2_pend),
    .rd_pend   (rd_pend)
  );

  // Issue decision; non-MDU instructions bypass a busy MDU.
  assign hazard    = (instr.use_rs1 & rs1_pend) | (instr.use_rs2 & rs2_pend) | (instr.wr_rd & rd_pend);
  assign dec_ready = ~flush & ~hazard & (~instr.is_md | (state == IDLE));
  assign issue     = dec_valid & dec_ready;
  assign alu_issue = issue & ~instr.is_md;
  assign md_start  = issue & instr.is_md;

  // A flush in WB suppresses the writeback; reset never raises a kill.
  assign md_busy     = (state != IDLE);
  assign md_kill     = flush & ~reset & (state != IDLE);
  assign md_wb_valid = (state == WB) & ~flush & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      md_rd <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            state <= BUSY;
            md_rd <= instr.rd;
          end
        end
        BUSY:    if (md_done) state <= WB;
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ISSUE_SCHED_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued       <= '0;
      stat_hazard_stall <= '0;
      stat_md_stall     <= '0;
    end else begin
      if (issue && (stat_issued != '1))
        stat_issued <= stat_issued + STAT_W'(1);
      if (dec_valid && hazard && !flush && (stat_hazard_stall != '1))
        stat_hazard_stall <= stat_hazard_stall + STAT_W'(1);
      if (dec_valid && instr.is_md && !hazard && (state != IDLE) && !flush && (stat_md_stall != '1))
        stat_md_stall <= stat_md_stall + STAT_W'(1);
    end
  end
`else
  // Statistics counters compiled out.
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed scenarios plus randomized
// traffic compared against a behavioural scoreboard/MDU model.
module tb_issue_scheduler;

  logic       clk;
  logic       reset;
  logic       dec_valid;
  logic       dec_ready;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;
  logic       dec_use_rs1, dec_use_rs2, dec_wr_rd, dec_is_md;
  logic       alu_issue, md_start;
  logic [4:0] md_rd;
  logic       md_done, md_kill, md_wb_valid;
  logic       alu_wb_valid;
  logic [4:0] alu_wb_rd;
  logic       flush;
  logic       md_busy;
`ifdef ISSUE_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_hazard_stall, stat_md_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  issue_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_rd       (dec_rd),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_use_rs1  (dec_use_rs1),
    .dec_use_rs2  (dec_use_rs2),
    .dec_wr_rd    (dec_wr_rd),
    .dec_is_md    (dec_is_md),
    .alu_issue    (alu_issue),
    .md_start     (md_start),
    .md_rd        (md_rd),
    .md_done      (md_done),
    .md_kill      (md_kill),
    .md_wb_valid  (md_wb_valid),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_rd    (alu_wb_rd),
    .flush        (flush),
`ifdef ISSUE_SCHED_STATS_EN
    .stat_issued       (stat_issued),
    .stat_hazard_stall (stat_hazard_stall),
    .stat_md_stall     (stat_md_stall),
`endif
    .md_busy      (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: set of pending registers and the MDU phase (0 idle, 1 busy, 2 writeback).
  logic [31:0] pm;
  int          ms;
  logic [4:0]  mrd;
  int          m_issued;

  function automatic logic f_hazard();
    return (dec_use_rs1 && pm[dec_rs1]) || (dec_use_rs2 && pm[dec_rs2]) || (dec_wr_rd && pm[dec_rd]);
  endfunction

  function automatic logic f_ready();
    return !flush && !f_hazard() && (!dec_is_md || ms == 0);
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] np;
    logic        iss;
    iss = dec_valid && f_ready();
    if (reset) begin
      pm <= '0; ms <= 0; mrd <= '0; m_issued <= 0;
    end else if (flush) begin
      pm <= '0; ms <= 0;
    end else begin
      np = pm;
      if (alu_wb_valid) np[alu_wb_rd] = 1'b0;
      if (ms == 2) np[mrd] = 1'b0;
      if (iss && dec_wr_rd && dec_rd != 0) np[dec_rd] = 1'b1;
      pm <= np;
      if (iss) m_issued <= m_issued + 1;
      if (ms == 0 && iss && dec_is_md) begin ms <= 1; mrd <= dec_rd; end
      else if (ms == 1 && md_done) ms <= 2;
      else if (ms == 2) ms <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    dec_valid = 0; dec_rd = 0; dec_rs1 = 0; dec_rs2 = 0;
    dec_use_rs1 = 0; dec_use_rs2 = 0; dec_wr_rd = 0; dec_is_md = 0;
    md_done = 0; alu_wb_valid = 0; alu_wb_rd = 0; flush = 0;
  endtask

  task automatic instr(input logic md, input int rd, input int rs1, input int rs2,
                       input logic u1, input logic u2, input logic wr);
    dec_valid = 1; dec_is_md = md;
    dec_rd = 5'(rd); dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2);
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_wr_rd = wr;
  endtask

  task automatic drain();
    tick(); idle_in(); flush = 1;
    tick(); flush = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_in();
    repeat (2) tick();
    @(negedge clk);
    n_checks++; if (md_busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", md_busy); end
    n_checks++; if (md_kill !== 1'b0)     begin n_fail++; $display("FAIL reset_kill got=%b exp=0", md_kill); end
    n_checks++; if (md_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb got=%b exp=0", md_wb_valid); end
    n_checks++; if ({alu_issue, md_start} !== 2'b00) begin n_fail++; $display("FAIL reset_issue got=%b%b exp=00", alu_issue, md_start); end
    n_checks++; if (md_rd !== 5'd0)       begin n_fail++; $display("FAIL reset_md_rd got=%0d exp=0", md_rd); end
    n_checks++; if (dec_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready got=%b exp=1", dec_ready); end
    tick(); reset = 0;
  endtask

  task automatic test_independent_alu();
    tick(); instr(0, 5, 1, 2, 1, 1, 1);
    @(negedge clk);
    n_checks++; if ({dec_ready, alu_issue} !== 2'b11) begin n_fail++; $display("FAIL alu_first got=%b%b exp=11", dec_ready, alu_issue); end
    tick(); instr(0, 6, 3, 4, 1, 1, 1);
    @(negedge clk);
    n_checks++; if ({alu_issue, md_start} !== 2'b10) begin n_fail++; $display("FAIL alu_second got=%b%b exp=10", alu_issue, md_start); end
    tick(); idle_in();
    @(negedge clk);
    n_checks++; if (alu_issue !== 1'b0) begin n_fail++; $display("FAIL alu_idle got=%b exp=0", alu_issue); end
    drain();
  endtask

  task automatic test_raw();
    tick(); instr(0, 5, 1, 2, 1, 1, 1);
    @(negedge clk);
    n_checks++; if (alu_issue !== 1'b1) begin n_fail++; $display("FAIL raw_producer got=%b exp=1", alu_issue); end
    for (int k = 0; k < 3; k++) begin
      tick(); instr(0, 10, 5, 1, 1, 1, 1);
      @(negedge clk);
      n_checks++; if ({dec_ready, alu_issue} !== 2'b00) begin n_fail++; $display("FAIL raw_stall%0d got=%b%b exp=00", k, dec_ready, alu_issue); end
    end
    tick(); alu_wb_valid = 1; alu_wb_rd = 5;
    @(negedge clk);
    n_checks++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL raw_wb_cycle got=%b exp=0", dec_ready); end
    tick(); alu_wb_valid = 0;
    @(negedge clk);
    n_checks++; if ({dec_ready, alu_issue} !== 2'b11) begin n_fail++; $display("FAIL raw_release got=%b%b exp=11", dec_ready, alu_issue); end
    drain();
  endtask

  task automatic test_mdu_seq();
    int busy_cnt = 0;
    for (int c = 0; c <= 6; c++) begin
      tick();
      md_done = (c == 4);
      if (c == 0)      instr(1, 7, 1, 2, 1, 1, 1);
      else if (c == 2) instr(0, 8, 1, 2, 1, 1, 1);
      else             instr(1, 11, 3, 4, 1, 1, 1);
      @(negedge clk);
      if (md_busy === 1'b1) busy_cnt++;
      case (c)
        0: begin n_checks++; if ({md_start, alu_issue} !== 2'b10) begin n_fail++; $display("FAIL md_start got=%b%b exp=10", md_start, alu_issue); end end
        2: begin n_checks++; if (alu_issue !== 1'b1) begin n_fail++; $display("FAIL md_alu_free got=%b exp=1", alu_issue); end end
        5: begin
             n_checks++; if ({md_wb_valid, dec_ready} !== 2'b10) begin n_fail++; $display("FAIL md_wb got=%b%b exp=10", md_wb_valid, dec_ready); end
             n_checks++; if (md_rd !== 5'd7) begin n_fail++; $display("FAIL md_rd got=%0d exp=7", md_rd); end
           end
        6: begin n_checks++; if ({md_wb_valid, md_start} !== 2'b01) begin n_fail++; $display("FAIL md_b2b got=%b%b exp=01", md_wb_valid, md_start); end end
        default: begin n_checks++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL md_block%0d got=%b exp=0", c, dec_ready); end end
      endcase
    end
    n_checks++; if (busy_cnt != 5) begin n_fail++; $display("FAIL md_busy_len got=%0d exp=5", busy_cnt); end
    tick(); idle_in();
    tick(); md_done = 1;
    tick(); md_done = 0;
    @(negedge clk);
    n_checks++; if ({md_wb_valid, md_rd} !== {1'b1, 5'd11}) begin n_fail++; $display("FAIL md_second_wb got=%b/%0d exp=1/11", md_wb_valid, md_rd); end
    drain();
  endtask

  task automatic test_set_clear();
    tick(); instr(0, 9, 1, 2, 1, 1, 1); alu_wb_valid = 1; alu_wb_rd = 9;
    @(negedge clk);
    n_checks++; if (alu_issue !== 1'b1) begin n_fail++; $display("FAIL setclr_issue got=%b exp=1", alu_issue); end
    tick(); alu_wb_valid = 0; instr(0, 3, 9, 0, 1, 0, 1);
    @(negedge clk);
    n_checks++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL setclr_pend got=%b exp=0", dec_ready); end
    drain();
  endtask

  task automatic test_flush();
    tick(); instr(1, 12, 1, 2, 1, 1, 1);
    @(negedge clk);
    n_checks++; if (md_start !== 1'b1) begin n_fail++; $display("FAIL flush_start got=%b exp=1", md_start); end
    tick(); instr(0, 13, 1, 2, 1, 1, 1);
    tick(); instr(0, 13, 12, 13, 1, 1, 1); flush = 1;
    @(negedge clk);
    n_checks++; if ({dec_ready, alu_issue, md_kill} !== 3'b001) begin n_fail++; $display("FAIL flush_kill got=%b%b%b exp=001", dec_ready, alu_issue, md_kill); end
    tick(); flush = 0;
    @(negedge clk);
    n_checks++; if ({md_kill, md_busy, alu_issue} !== 3'b001) begin n_fail++; $display("FAIL flush_after got=%b%b%b exp=001", md_kill, md_busy, alu_issue); end
    tick(); idle_in(); md_done = 1;
    tick(); md_done = 0;
    @(negedge clk);
    n_checks++; if ({md_wb_valid, md_busy} !== 2'b00) begin n_fail++; $display("FAIL flush_late_done got=%b%b exp=00", md_wb_valid, md_busy); end
    drain();
  endtask

  task automatic test_x0_and_reset();
    tick(); instr(0, 0, 1, 2, 1, 1, 1);
    tick(); instr(0, 0, 0, 0, 1, 1, 1);
    @(negedge clk);
    n_checks++; if ({dec_ready, alu_issue} !== 2'b11) begin n_fail++; $display("FAIL x0_no_stall got=%b%b exp=11", dec_ready, alu_issue); end
    tick(); instr(1, 14, 0, 0, 1, 1, 1);
    tick(); idle_in();
    tick(); reset = 1;
    @(negedge clk);
    n_checks++; if ({md_kill, md_wb_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_kill got=%b%b exp=00", md_kill, md_wb_valid); end
    tick(); reset = 0; instr(0, 15, 14, 0, 1, 0, 1);
    @(negedge clk);
    n_checks++; if ({md_busy, dec_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_after got=%b%b exp=01", md_busy, dec_ready); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick();
      reset        = ($urandom_range(63) == 0);
      flush        = ($urandom_range(19) == 0);
      md_done      = ($urandom_range(3) == 0);
      alu_wb_valid = ($urandom_range(2) == 0);
      alu_wb_rd    = 5'($urandom_range(7));
      dec_valid    = ($urandom_range(4) != 0);
      dec_is_md    = ($urandom_range(2) == 0);
      dec_rd       = 5'($urandom_range(7));
      dec_rs1      = 5'($urandom_range(7));
      dec_rs2      = 5'($urandom_range(7));
      dec_use_rs1  = 1'($urandom_range(1));
      dec_use_rs2  = 1'($urandom_range(1));
      dec_wr_rd    = ($urandom_range(3) != 0);
      @(negedge clk);
      n_checks++;
      if ({dec_ready, alu_issue, md_start, md_kill, md_wb_valid, md_busy, md_rd} !==
          {f_ready(), dec_valid && f_ready() && !dec_is_md, dec_valid && f_ready() && dec_is_md,
           flush && !reset && ms != 0, ms == 2 && !flush && !reset, ms != 0, mrd}) begin
        n_fail++;
        $display("FAIL rand_cycle%0d got rdy=%b alu=%b st=%b kill=%b wb=%b busy=%b rd=%0d exp rdy=%b ms=%0d mrd=%0d",
                 i, dec_ready, alu_issue, md_start, md_kill, md_wb_valid, md_busy, md_rd, f_ready(), ms, mrd);
      end
    end
    tick(); reset = 0; idle_in();
`ifdef ISSUE_SCHED_STATS_EN
    @(negedge clk);
    n_checks++; if (stat_issued !== 32'(m_issued)) begin n_fail++; $display("FAIL stat_issued got=%0d exp=%0d", stat_issued, m_issued); end
`endif
    drain();
  endtask

  initial begin
    reset = 1;
    idle_in();
    test_reset();
    test_independent_alu();
    test_raw();
    test_mdu_seq();
    test_set_clear();
    test_flush();
    test_x0_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
